key_round_memory: RTL and testbench
===================================

# key_round_memory

Round-key store between the key-expansion front end and the AES round datapath. It captures each 128-bit subkey as the expander emits it and keeps one valid bit per entry. Valid bits are cleared when a new key arrives. The round datapath reads round keys through a request/acknowledge handshake that stalls until the requested key has been written.

## Interface
Parameters:
- NUM_ENTRIES, 15: round-key slots (AES-256 needs Nr+1 = 15).
- KEY_W, 128: subkey width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Asserting low clears state immediately; release is synchronous to clk.
- wr_valid  in  1  expander subkey valid; one write per cycle.
- waddr  in  4  round index of the incoming subkey.
- subkey  in  KEY_W  subkey data.
- reset_valid_bits  in  1  single-cycle pulse that clears all valid bits (new key accepted).
- key_len  in  2  active key length: 01 = 128, 10 = 192, 11 = 256, 00 = none.
- rd_req  in  1  round-key read request; held high until rd_ack.
- raddr  in  4  requested round index; stable while rd_req is high.
- rd_ack  out  1  one-cycle pulse; rd_data and rd_err are valid in this cycle.
- rd_data  out  KEY_W  requested round key.
- rd_err  out  1  with rd_ack: the address is out of range for key_len.
- keys_ready  out  1  all entries 0..Nr are valid for the current key_len.

## Operation
- Nr is 10, 12 or 14 for key_len 01, 10 or 11. For key_len 00 no index is in range.
- Storage is a register array of NUM_ENTRIES x KEY_W. The data array is not reset; valid[14:0] is reset to 0.
- Write: when wr_valid=1 and waddr<NUM_ENTRIES, mem[waddr] <= subkey and valid[waddr] <= 1.
  - A write with waddr>=15 is dropped.
  - A write with waddr>Nr is still stored but does not affect keys_ready.
- Clear: when reset_valid_bits=1, all valid bits go to 0.
  - If a write occurs in the same cycle, the clear is applied first and the write second. The written entry ends valid and all others end invalid.
- keys_ready is combinational: AND of valid[0..Nr]. It is 0 when key_len=00.
- Read FSM has two states, IDLE and WAIT. One request is outstanding at a time.
- IDLE: rd_req is sampled only when rd_ack=0 in the current cycle.
  - Out-of-range raddr (raddr>Nr, or key_len=00): next cycle rd_ack=1, rd_err=1, rd_data=0. Stay in IDLE.
  - valid[raddr]=1: next cycle rd_ack=1, rd_err=0, rd_data=mem[raddr]. Stay in IDLE.
  - A write to raddr in the same cycle: forward subkey, same as the valid case.
  - Otherwise: latch raddr into pend_addr and go to WAIT.
- WAIT:
  - rd_req=0: abandon the request, no ack, return to IDLE.
  - valid[pend_addr]=1, or a same-cycle write to pend_addr: ack next cycle with that data (forwarded when written). Return to IDLE.
  - reset_valid_bits while in WAIT: keep waiting. The ack comes only after the new key's entry is written.
  - A key_len change while in WAIT does not re-check range; range is checked only in IDLE.
- Outputs are registered. rd_data holds its last value after an ack; rd_err is 0 whenever rd_ack=0.

## Timing
- Reset values: rd_ack=0, rd_err=0, rd_data=0, keys_ready=0, FSM=IDLE, valid=0.
- Write-to-visible latency:
  - A write at edge T sets valid after T.
  - keys_ready rises in the cycle after the last required write.
  - A read pending on that entry acks in the cycle after the write edge (forwarding path).
- Read hit latency is 1 cycle: rd_req sampled at edge T, rd_ack high during the cycle after T.
- Back-to-back reads: the requester drops rd_req or changes raddr in the ack cycle. rd_req is ignored during the ack cycle, so peak throughput is one read per 2 cycles.
- Reset mid-operation: the FSM returns to IDLE immediately, any pending read is lost with no ack, and all valid bits are cleared.

## Test plan
- Key_len=01; write waddr 0..10 with subkey = {16{8'hA0+i}}; keys_ready rises the cycle after the waddr=10 write. Read raddr=5 -> rd_ack next cycle with {16{8'hA5}}, rd_err=0.
- Key_len=01, raddr=12 -> rd_ack=1, rd_err=1, rd_data=0. Key_len=11, raddr=14 after all writes -> valid data.
- Stall: rd_req raddr=3 with valid[3]=0 -> FSM in WAIT, rd_ack=0. Write waddr=3 = 128'hDEADBEEF... 6 cycles later -> rd_ack the next cycle with that value.
- Same-cycle reset_valid_bits and wr_valid waddr=0 -> only valid[0]=1; keys_ready=0; read raddr=1 stalls.
- Abandon: enter WAIT on raddr=7, drop rd_req, then write waddr=7 -> no rd_ack.
- Pull reset low during WAIT, asynchronously between edges -> rd_ack=0, keys_ready=0 immediately; after release, read raddr=0 stalls until rewritten.

Source files
------------

// File: rtl/key_round_memory_if.sv
// rtl/key_round_memory_if.sv - subkey write and round-key read handshake bundle
interface key_round_memory_if #(
    parameter int KEY_W = 128
);
    logic             wr_valid;
    logic [3:0]       waddr;
    logic [KEY_W-1:0] subkey;
    logic             rd_req;
    logic [3:0]       raddr;
    logic             rd_ack;
    logic [KEY_W-1:0] rd_data;
    logic             rd_err;

    modport master (
        output wr_valid, waddr, subkey, rd_req, raddr,
        input  rd_ack, rd_data, rd_err
    );

    modport slave (
        input  wr_valid, waddr, subkey, rd_req, raddr,
        output rd_ack, rd_data, rd_err
    );
endinterface

// File: rtl/key_round_memory.sv
// rtl/key_round_memory.sv - round-key store with per-entry valid bits and stalling read port
module key_round_memory #(
    parameter int NUM_ENTRIES = 15,
    parameter int KEY_W       = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reset_valid_bits,
    input  logic [1:0]        key_len,
    output logic              keys_ready,
    key_round_memory_if.slave bus
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state, state_d;
    logic [KEY_W-1:0]       mem [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid, valid_d, ready_mask;
    logic [3:0]             nr, pend_addr, lookup_addr;
    logic                   wr_hit, fwd, hit, idle_take, range_err;
    logic                   ack_d, err_d, rd_ack_q, rd_err_q;
    logic [KEY_W-1:0]       data_d, rd_data_q;

    always_comb begin
        case (key_len)
            2'b01:   nr = 4'd10;
            2'b10:   nr = 4'd12;
            default: nr = 4'd14;
        endcase
    end

    assign wr_hit    = bus.wr_valid && (int'(bus.waddr) < NUM_ENTRIES);
    assign range_err = (key_len == 2'b00) || (bus.raddr > nr);

    always_comb begin
        ready_mask = '0;
        for (int i = 0; i < NUM_ENTRIES; i++)
            ready_mask[i] = (i <= int'(nr));
    end

    assign keys_ready = (key_len != 2'b00) && (&(valid | ~ready_mask));

    // Clear first, then the same-cycle write lands on the freshly cleared set.
    always_comb begin
        valid_d = valid;
        if (reset_valid_bits)
            valid_d = '0;
        if (wr_hit)
            valid_d[bus.waddr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_hit)
            mem[bus.waddr] <= bus.subkey;
    end

    // IDLE looks at the live request address, WAIT at the latched one.
    assign lookup_addr = (state == S_WAIT) ? pend_addr : bus.raddr;
    assign fwd         = wr_hit && (bus.waddr == lookup_addr);
    assign hit         = fwd || valid[lookup_addr];
    assign idle_take   = (state == S_IDLE) && bus.rd_req && !rd_ack_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            valid     <= '0;
            pend_addr <= '0;
            rd_ack_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state    <= state_d;
            valid    <= valid_d;
            rd_ack_q <= ack_d;
            rd_err_q <= err_d;
            if (idle_take)
                pend_addr <= bus.raddr;
            if (ack_d)
                rd_data_q <= data_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: if (idle_take && !range_err && !hit) state_d = S_WAIT;
            S_WAIT: if (!bus.rd_req || hit)              state_d = S_IDLE;
            default:                                     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ack_d  = 1'b0;
        err_d  = 1'b0;
        data_d = fwd ? bus.subkey : mem[lookup_addr];
        case (state)
            S_IDLE: begin
                if (idle_take && range_err) begin
                    ack_d  = 1'b1;
                    err_d  = 1'b1;
                    data_d = '0;
                end else if (idle_take && hit) begin
                    ack_d = 1'b1;
                end
            end
            S_WAIT:  ack_d = bus.rd_req && hit;
            default: ack_d = 1'b0;
        endcase
    end

    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_err  = rd_err_q;
    assign bus.rd_data = rd_data_q;
endmodule

// File: tb/tb_key_round_memory.sv
// tb/tb_key_round_memory.sv - directed bench for key_round_memory
module tb_key_round_memory;
    logic       clk = 1'b0;
    logic       reset;
    logic       reset_valid_bits;
    logic [1:0] key_len;
    logic       keys_ready;
    int         checks = 0;
    int         errors = 0;

    localparam logic [127:0] DB = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
    localparam logic [127:0] K0 = 128'h0123456789ABCDEF_FEDCBA9876543210;

    key_round_memory_if bus ();

    key_round_memory dut (
        .clk              (clk),
        .reset            (reset),
        .reset_valid_bits (reset_valid_bits),
        .key_len          (key_len),
        .keys_ready       (keys_ready),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] pat(input int i);
        logic [7:0] b;
        b = 8'hA0 + 8'(i);
        return {16{b}};
    endfunction

    task automatic write(input int a, input logic [127:0] d);
        bus.wr_valid = 1'b1;
        bus.waddr    = 4'(a);
        bus.subkey   = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic read_once(input int a);
        bus.rd_req = 1'b1;
        bus.raddr  = 4'(a);
        step();
        bus.rd_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0; reset_valid_bits = 1'b0; key_len = 2'b00;
        bus.wr_valid = 1'b0; bus.waddr = '0; bus.subkey = '0;
        bus.rd_req = 1'b0; bus.raddr = '0;
        repeat (2) @(negedge clk);
        check("rst_ack",   128'(bus.rd_ack), 128'd0);
        check("rst_err",   128'(bus.rd_err), 128'd0);
        check("rst_data",  bus.rd_data,      128'd0);
        check("rst_ready", 128'(keys_ready), 128'd0);

        reset = 1'b1;
        key_len = 2'b01;
        for (int i = 0; i < 10; i++) write(i, pat(i));
        check("ready_early", 128'(keys_ready), 128'd0);
        write(10, pat(10));
        check("ready_rise", 128'(keys_ready), 128'd1);

        read_once(5);
        check("hit_ack",  128'(bus.rd_ack), 128'd1);
        check("hit_data", bus.rd_data,      pat(5));
        check("hit_err",  128'(bus.rd_err), 128'd0);
        step();
        check("ack_drop",  128'(bus.rd_ack), 128'd0);
        check("data_hold", bus.rd_data,      pat(5));

        bus.rd_req = 1'b1; bus.raddr = 4'd0;
        step();
        check("b2b_ack0", 128'(bus.rd_ack), 128'd1);
        bus.raddr = 4'd1;
        step();
        check("b2b_gap", 128'(bus.rd_ack), 128'd0);
        step();
        check("b2b_ack1",  128'(bus.rd_ack), 128'd1);
        check("b2b_data1", bus.rd_data,      pat(1));
        bus.rd_req = 1'b0;
        step();

        read_once(12);
        check("oor_ack",  128'(bus.rd_ack), 128'd1);
        check("oor_err",  128'(bus.rd_err), 128'd1);
        check("oor_data", bus.rd_data,      128'd0);
        step();
        check("oor_err_clear", 128'(bus.rd_err), 128'd0);

        for (int i = 11; i < 15; i++) write(i, pat(i));
        check("ready_beyond_nr", 128'(keys_ready), 128'd1);
        key_len = 2'b11;
        #1 check("ready_256", 128'(keys_ready), 128'd1);
        read_once(14);
        check("r14_ack",  128'(bus.rd_ack), 128'd1);
        check("r14_err",  128'(bus.rd_err), 128'd0);
        check("r14_data", bus.rd_data,      pat(14));
        step();

        key_len = 2'b00;
        #1 check("ready_none", 128'(keys_ready), 128'd0);
        read_once(0);
        check("none_err", 128'(bus.rd_err), 128'd1);
        step();
        key_len = 2'b11;

        reset_valid_bits = 1'b1;
        step();
        reset_valid_bits = 1'b0;
        check("clr_ready", 128'(keys_ready), 128'd0);
        bus.rd_req = 1'b1; bus.raddr = 4'd3;
        for (int k = 0; k < 6; k++) begin
            step();
            check("stall_ack", 128'(bus.rd_ack), 128'd0);
        end
        write(3, DB);
        check("fwd_ack",  128'(bus.rd_ack), 128'd1);
        check("fwd_data", bus.rd_data,      DB);
        bus.rd_req = 1'b0;
        step();

        reset_valid_bits = 1'b1;
        write(0, K0);
        reset_valid_bits = 1'b0;
        check("same_ready", 128'(keys_ready), 128'd0);
        read_once(0);
        check("same_r0_ack",  128'(bus.rd_ack), 128'd1);
        check("same_r0_data", bus.rd_data,      K0);
        step();
        bus.rd_req = 1'b1; bus.raddr = 4'd1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("same_r1_stall", 128'(bus.rd_ack), 128'd0);
        end
        bus.rd_req = 1'b0;
        step();

        read_once(7);
        check("abn_wait", 128'(bus.rd_ack), 128'd0);
        step();
        write(7, pat(7));
        check("abn_noack0", 128'(bus.rd_ack), 128'd0);
        step();
        check("abn_noack1", 128'(bus.rd_ack), 128'd0);
        read_once(7);
        check("abn_r7_data", bus.rd_data, pat(7));

        reset_valid_bits = 1'b1;
        step();
        reset_valid_bits = 1'b0;
        for (int i = 0; i < 11; i++) write(i, pat(i));
        bus.rd_req = 1'b1; bus.raddr = 4'd14;
        step();
        check("rw_wait", 128'(bus.rd_ack), 128'd0);
        key_len = 2'b01;
        #1 check("rw_ready", 128'(keys_ready), 128'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_ack",   128'(bus.rd_ack), 128'd0);
        check("arst_ready", 128'(keys_ready), 128'd0);
        check("arst_data",  bus.rd_data,      128'd0);
        bus.rd_req = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b1;
        bus.rd_req = 1'b1; bus.raddr = 4'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_stall", 128'(bus.rd_ack), 128'd0);
        end
        write(0, DB);
        check("post_rst_ack",  128'(bus.rd_ack), 128'd1);
        check("post_rst_data", bus.rd_data,      DB);
        bus.rd_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
